// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue sequencer: FSM states, ALU select
// encodings and command byte field positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_OPA,
    ST_OPB,
    ST_EXEC,
    ST_RESP
  } seq_state_e;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_NAND  = 3'b111;

  localparam int unsigned CMD_SEL_LSB   = 0;
  localparam int unsigned CMD_SEL_W     = 3;
  localparam int unsigned CMD_SHIFT_BIT = 3;
  localparam int unsigned CMD_RSVD_LSB  = 4;

  localparam int unsigned EXEC_CNT_W = 4;

endpackage

// File: rtl/alu_exec_timer.sv
// Loadable down-counter that times the ALU execution window; done_o is high
// while the count sits at zero.
module alu_exec_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit ALU: collects command/A/B bytes, drives registered
// operands for a fixed execution window, then hands {cout, result} downstream.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  output logic              alu_shift,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_cout,
  output logic [DATA_W:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err
);

  localparam logic [EXEC_CNT_W-1:0] ExecLoad = EXEC_CNT_W'(EXEC_CYCLES - 1);

  seq_state_e state_q, state_d;

  logic [CMD_SEL_W-1:0] cmd_sel_q, cmd_sel_d;
  logic                 cmd_shift_q, cmd_shift_d;
  logic [DATA_W-1:0]    opa_q, opa_d;
  logic [DATA_W-1:0]    alu_a_q, alu_a_d;
  logic [DATA_W-1:0]    alu_b_q, alu_b_d;
  logic [2:0]           alu_sel_q, alu_sel_d;
  logic                 alu_shift_q, alu_shift_d;
  logic [DATA_W:0]      out_q, out_d;
  logic                 err_q, err_d;

  logic beat;
  logic rsvd_nz;
  logic timer_load;
  logic timer_en;
  logic timer_done;

  // in_ready is forced low during reset so no byte can slip in while state is clearing
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      ST_CMD, ST_OPA, ST_OPB: in_ready = !rst;
      default:                in_ready = 1'b0;
    endcase
  end

  assign beat      = in_valid && in_ready;
  assign rsvd_nz   = |in_data[DATA_W-1:CMD_RSVD_LSB];
  assign out_valid = (state_q == ST_RESP) && !rst;
  assign busy      = (state_q != ST_CMD);
  assign timer_en  = (state_q == ST_EXEC);

  always_comb begin
    state_d     = state_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_shift_d = cmd_shift_q;
    opa_d       = opa_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    alu_shift_d = alu_shift_q;
    out_d       = out_q;
    err_d       = 1'b0;
    timer_load  = 1'b0;

    unique case (state_q)
      ST_CMD: begin
        if (beat) begin
          if (rsvd_nz) begin
            err_d = 1'b1;
          end else begin
            cmd_sel_d   = in_data[CMD_SEL_LSB +: CMD_SEL_W];
            cmd_shift_d = in_data[CMD_SHIFT_BIT];
            state_d     = ST_OPA;
          end
        end
      end
      ST_OPA: begin
        if (beat) begin
          opa_d   = in_data;
          state_d = ST_OPB;
        end
      end
      ST_OPB: begin
        // All ALU drives change together here and nowhere else
        if (beat) begin
          alu_a_d     = opa_q;
          alu_b_d     = in_data;
          alu_sel_d   = cmd_sel_q;
          alu_shift_d = cmd_shift_q;
          timer_load  = 1'b1;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (timer_done) begin
          out_d   = {alu_cout, alu_o};
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_CMD;
        end
      end
      default: begin
        state_d = ST_CMD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CMD;
      cmd_sel_q   <= '0;
      cmd_shift_q <= 1'b0;
      opa_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_shift_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_shift_q <= cmd_shift_d;
      opa_q       <= opa_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_shift_q <= alu_shift_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  alu_exec_timer #(
    .CNT_W(EXEC_CNT_W)
  ) u_exec_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .load_val_i(ExecLoad),
    .en_i      (timer_en),
    .done_o    (timer_done)
  );

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_shift = alu_shift_q;
  assign out_data  = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: two instances (EXEC_CYCLES 2 and 1) each
// wired to a behavioural ALU; expected results are queued as commands are sent.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in_data   [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] alu_a     [2];
  logic [W-1:0] alu_b     [2];
  logic [2:0]   alu_sel   [2];
  logic         alu_shift [2];
  logic [W-1:0] alu_o     [2];
  logic         alu_cout  [2];
  logic [W:0]   out_data  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         busy      [2];
  logic         err       [2];

  int checks   = 0;
  int failures = 0;

  logic [W:0] sb0 [$];
  logic [W:0] sb1 [$];
  logic [W:0] exp0, exp1;

  function automatic logic [W:0] alu_model(input logic [2:0] sel, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic sh);
    logic [2*W-1:0] p;
    p = a * b;
    case (sel)
      OP_ADD:   return {1'b0, a} + {1'b0, b};
      OP_SUB:   return {1'b0, a} - {1'b0, b};
      OP_MUL:   return {|p[2*W-1:W], p[W-1:0]};
      OP_SHIFT: return sh ? {a[W-1], a << 1} : {a[0], a >> 1};
      OP_OR:    return {1'b0, a | b};
      OP_NOT:   return {1'b0, ~a};
      OP_XOR:   return {1'b0, a ^ b};
      OP_NAND:  return {1'b0, ~(a & b)};
      default:  return '0;
    endcase
  endfunction

  assign {alu_cout[0], alu_o[0]} = alu_model(alu_sel[0], alu_a[0], alu_b[0], alu_shift[0]);
  assign {alu_cout[1], alu_o[1]} = alu_model(alu_sel[1], alu_a[1], alu_b[1], alu_shift[1]);

  alu_op_sequencer #(.DATA_W(W), .EXEC_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_shift(alu_shift[0]),
    .alu_o(alu_o[0]), .alu_cout(alu_cout[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .err(err[0])
  );

  alu_op_sequencer #(.DATA_W(W), .EXEC_CYCLES(1)) u_dut_ec1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_shift(alu_shift[1]),
    .alu_o(alu_o[1]), .alu_cout(alu_cout[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .err(err[1])
  );

  // Output monitors: every downstream transfer must match the oldest queued result
  always @(negedge clk) begin
    if (out_valid[0] && out_ready[0]) begin
      checks++;
      if (sb0.size() == 0) begin
        failures++;
        $display("FAIL sb0_unexpected: got %h, required no transfer", out_data[0]);
      end else begin
        exp0 = sb0.pop_front();
        if (out_data[0] !== exp0) begin
          failures++;
          $display("FAIL sb0_data: got %h, required %h", out_data[0], exp0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid[1] && out_ready[1]) begin
      checks++;
      if (sb1.size() == 0) begin
        failures++;
        $display("FAIL sb1_unexpected: got %h, required no transfer", out_data[1]);
      end else begin
        exp1 = sb1.pop_front();
        if (out_data[1] !== exp1) begin
          failures++;
          $display("FAIL sb1_data: got %h, required %h", out_data[1], exp1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge
  task automatic send_byte(input int d, input logic [W-1:0] b);
    int n;
    n = 0;
    in_data[d]  = b;
    in_valid[d] = 1'b1;
    @(negedge clk);
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic send_op(input int d, input logic [W-1:0] cmd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push);
    logic [W:0] e;
    e = alu_model(cmd[2:0], a, b, cmd[3]);
    if (push) begin
      if (d == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
    send_byte(d, cmd);
    send_byte(d, a);
    send_byte(d, b);
  endtask

  // n counts edges inclusive of the B accept edge; returns at the negedge with out_valid high
  task automatic wait_valid(input int d, output int n);
    n = 1;
    @(negedge clk);
    while (!out_valid[d] && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (!out_valid[d]) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout: got out_valid=0 after 40 edges, required 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready_low: got %b, required 0", in_ready[0]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready_high: got %b, required 1", in_ready[0]);
    end
    checks++;
    if ({out_valid[0], err[0], busy[0], out_data[0]} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b err=%b busy=%b data=%h, required all 0",
               out_valid[0], err[0], busy[0], out_data[0]);
    end
    checks++;
    if ({alu_a[0], alu_b[0], alu_sel[0], alu_shift[0]} !== '0) begin
      failures++;
      $display("FAIL reset_alu: got a=%h b=%h sel=%b sh=%b, required all 0",
               alu_a[0], alu_b[0], alu_sel[0], alu_shift[0]);
    end
  endtask

  task automatic test_basic_add();
    int n;
    send_op(0, 8'h00, 8'h3C, 8'h0F, 1'b1);
    checks++;
    if ({alu_sel[0], alu_a[0], alu_b[0]} !== {3'b000, 8'h3C, 8'h0F}) begin
      failures++;
      $display("FAIL add_alu_drive: got sel=%b a=%h b=%h, required 000 3c 0f",
               alu_sel[0], alu_a[0], alu_b[0]);
    end
    wait_valid(0, n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL add_latency: got %0d edges, required 3", n);
    end
    checks++;
    if (out_data[0] !== 9'h04B) begin
      failures++;
      $display("FAIL add_data: got %h, required 04b", out_data[0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    send_op(0, 8'h00, 8'hF0, 8'h20, 1'b1);
    wait_valid(0, n);
    checks++;
    if (out_data[0] !== 9'h110) begin
      failures++;
      $display("FAIL add_carry: got %h, required 110", out_data[0]);
    end
    tick();
    checks++;
    if ({in_ready[0], busy[0]} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_ready: got ready=%b busy=%b, required 1 0", in_ready[0], busy[0]);
    end
    send_op(0, 8'h01, 8'h05, 8'h07, 1'b1);
    wait_valid(0, n);
    checks++;
    if (out_data[0] !== 9'h1FE) begin
      failures++;
      $display("FAIL sub_borrow: got %h, required 1fe", out_data[0]);
    end
    tick();
  endtask

  task automatic test_err();
    int n;
    send_byte(0, 8'h50);
    checks++;
    if ({err[0], busy[0], in_ready[0]} !== 3'b101) begin
      failures++;
      $display("FAIL err_pulse: got err=%b busy=%b ready=%b, required 1 0 1",
               err[0], busy[0], in_ready[0]);
    end
    tick();
    checks++;
    if (err[0] !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle: got %b, required 0", err[0]);
    end
    send_op(0, 8'h06, 8'hAA, 8'h0F, 1'b1);
    wait_valid(0, n);
    checks++;
    if (out_data[0] !== 9'h0A5) begin
      failures++;
      $display("FAIL xor_after_err: got %h, required 0a5", out_data[0]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    logic [W:0] held;
    out_ready[0] = 1'b0;
    send_op(0, 8'h04, 8'h12, 8'h40, 1'b1);
    wait_valid(0, n);
    held = out_data[0];
    checks++;
    if (held !== 9'h052) begin
      failures++;
      $display("FAIL or_data: got %h, required 052", held);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({out_valid[0], in_ready[0], out_data[0]} !== {2'b10, held}) begin
        failures++;
        $display("FAIL hold_cycle%0d: got valid=%b ready=%b data=%h, required 1 0 %h",
                 i, out_valid[0], in_ready[0], out_data[0], held);
      end
    end
    out_ready[0] = 1'b1;
    tick();
    checks++;
    if ({out_valid[0], in_ready[0]} !== 2'b01) begin
      failures++;
      $display("FAIL release: got valid=%b ready=%b, required 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_reset_mid_exec();
    int n;
    int stray;
    send_op(0, 8'h02, 8'h10, 8'h11, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid[0], busy[0], out_data[0]} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got valid=%b busy=%b data=%h, required all 0",
               out_valid[0], busy[0], out_data[0]);
    end
    checks++;
    if ({alu_a[0], alu_b[0], alu_sel[0], alu_shift[0]} !== '0) begin
      failures++;
      $display("FAIL midrst_alu: got a=%h b=%h sel=%b sh=%b, required all 0",
               alu_a[0], alu_b[0], alu_sel[0], alu_shift[0]);
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[0] !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL midrst_stale: got %0d valid cycles, required 0", stray);
    end
    send_op(0, 8'h07, 8'hF0, 8'h3C, 1'b1);
    wait_valid(0, n);
    checks++;
    if (out_data[0] !== 9'h0CF) begin
      failures++;
      $display("FAIL nand_after_rst: got %h, required 0cf", out_data[0]);
    end
    tick();
  endtask

  task automatic test_exec_one();
    int n;
    send_op(1, 8'h0B, 8'h81, 8'h00, 1'b1);
    checks++;
    if ({alu_sel[1], alu_shift[1], alu_a[1]} !== {3'b011, 1'b1, 8'h81}) begin
      failures++;
      $display("FAIL ec1_alu_drive: got sel=%b sh=%b a=%h, required 011 1 81",
               alu_sel[1], alu_shift[1], alu_a[1]);
    end
    wait_valid(1, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL ec1_latency: got %0d edges, required 2", n);
    end
    checks++;
    if (out_data[1] !== 9'h102) begin
      failures++;
      $display("FAIL ec1_shift_data: got %h, required 102", out_data[1]);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_err();
    test_backpressure();
    test_reset_mid_exec();
    test_exec_one();
    repeat (3) tick();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d/%0d pending, required 0/0", sb0.size(), sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
